// File: rtl/clsf_feature_packer.sv
// Packs NUM_WORDS RX FIFO words MSB-first into one feature vector and strobes it to the tree.
// Waits the fixed tree latency, captures the result bits and returns them on a valid/ready handshake.
module clsf_feature_packer #(
    parameter int WORD_W     = 64,
    parameter int NUM_WORDS  = 27,
    parameter int VEC_W      = 1728,
    parameter int RESULT_LAT = 5,
    parameter int CNT_W      = 16
) (
    input  logic              rx_fifo_clock,
    input  logic              rx_fifo_reset,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [WORD_W-1:0] fifo_dout,
    output logic [VEC_W-1:0]  data_out,
    output logic              data_valid,
    input  logic              clsf_result0,
    input  logic              clsf_result1,
    input  logic              clsf_result2,
    input  logic              clsf_result_mul,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [3:0]        result_bits,
    output logic [CNT_W-1:0]  vec_count,
    output logic              busy
);

    localparam int WC_W  = $clog2(NUM_WORDS + 1);
    localparam int LAT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

    typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_REPORT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_rd_en;
    logic [WC_W-1:0]    r_req_cnt;
    logic [WC_W-1:0]    r_rcv_cnt;
    logic               r_pend;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [VEC_W-1:0]   r_pack;
    logic [VEC_W-1:0]   r_data_out;
    logic               r_data_valid;
    logic [3:0]         r_result_bits;
    logic               r_result_valid;
    logic [CNT_W-1:0]   r_vec_count;

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        case (r_state)
            S_FILL: begin
                w_rd_en = !fifo_empty && (r_req_cnt < WC_W'(NUM_WORDS));
                if (r_rcv_cnt == WC_W'(NUM_WORDS)) w_next = S_ISSUE;
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (r_lat_cnt == '0) w_next = S_REPORT;
            end
            S_REPORT: begin
                if (result_ready) w_next = S_FILL;
            end
            default: w_next = S_FILL;
        endcase
    end

    always_ff @(posedge rx_fifo_clock or posedge rx_fifo_reset) begin
        if (rx_fifo_reset) begin
            r_state        <= S_FILL;
            r_req_cnt      <= '0;
            r_rcv_cnt      <= '0;
            r_pend         <= 1'b0;
            r_lat_cnt      <= '0;
            r_pack         <= '0;
            r_data_out     <= '0;
            r_data_valid   <= 1'b0;
            r_result_bits  <= '0;
            r_result_valid <= 1'b0;
            r_vec_count    <= '0;
        end else begin
            r_state      <= w_next;
            r_pend       <= w_rd_en;
            r_data_valid <= 1'b0;
            if (w_rd_en) r_req_cnt <= r_req_cnt + WC_W'(1);
            // Read data lands one cycle after the pop; slot 0 is the most significant word.
            if (r_pend) begin
                for (int k = 0; k < NUM_WORDS; k++) begin
                    if (r_rcv_cnt == WC_W'(k))
                        r_pack[(NUM_WORDS-1-k)*WORD_W +: WORD_W] <= fifo_dout;
                end
                r_rcv_cnt <= r_rcv_cnt + WC_W'(1);
            end
            case (r_state)
                S_FILL: begin
                    // Load on entry so vector and strobe are both present during the ISSUE cycle.
                    if (w_next == S_ISSUE) begin
                        r_data_out   <= r_pack;
                        r_data_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_req_cnt <= '0;
                    r_rcv_cnt <= '0;
                    r_lat_cnt <= LAT_W'(RESULT_LAT - 1);
                end
                S_WAIT: begin
                    if (r_lat_cnt == '0) begin
                        r_result_bits  <= {clsf_result_mul, clsf_result2, clsf_result1, clsf_result0};
                        r_result_valid <= 1'b1;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
                S_REPORT: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_vec_count    <= r_vec_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign fifo_rd_en   = w_rd_en;
    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign result_valid = r_result_valid;
    assign result_bits  = r_result_bits;
    assign vec_count    = r_vec_count;
    assign busy         = (r_state != S_FILL) || (r_rcv_cnt != '0) || (r_req_cnt != '0);

endmodule

// File: tb/tb_clsf_feature_packer.sv
// Directed bench for clsf_feature_packer: behavioural RX FIFO, hand-computed vectors and results.
module tb_clsf_feature_packer;

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [63:0]   fifo_dout = '0;
    logic [1727:0] data_out;
    logic          data_valid;
    logic          r0, r1, r2, rm;
    logic          result_valid;
    logic          result_ready;
    logic [3:0]    result_bits;
    logic [3:0]    vec_count;
    logic          busy;

    logic [63:0]   q[$];
    int            pops = 0;
    bit            gap_mode = 1'b0;
    int            checks = 0;
    int            failures = 0;

    clsf_feature_packer #(.WORD_W(64), .NUM_WORDS(27), .VEC_W(1728), .RESULT_LAT(5), .CNT_W(4)) dut (
        .rx_fifo_clock(clk), .rx_fifo_reset(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .data_out(data_out), .data_valid(data_valid),
        .clsf_result0(r0), .clsf_result1(r1), .clsf_result2(r2), .clsf_result_mul(rm),
        .result_valid(result_valid), .result_ready(result_ready), .result_bits(result_bits),
        .vec_count(vec_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // FIFO model: every pop request is counted, data returns one cycle later.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            pops <= pops + 1;
            if (q.size() > 0) fifo_dout <= q.pop_front();
        end
    end

    function automatic logic [1727:0] mkvec(input logic [63:0] base);
        logic [1727:0] v;
        v = '0;
        for (int k = 0; k < 27; k++) v[(26-k)*64 +: 64] = base + 64'(k);
        return v;
    endfunction

    task automatic set_empty();
        fifo_empty = (q.size() == 0) || (gap_mode && ($urandom_range(0, 1) == 0));
    endtask

    task automatic step();
        @(negedge clk);
        set_empty();
    endtask

    task automatic set_res(input logic [3:0] v);
        {rm, r2, r1, r0} = v;
    endtask

    task automatic push_vec(input logic [63:0] base);
        for (int k = 0; k < 27; k++) q.push_back(base + 64'(k));
        set_empty();
    endtask

    task automatic wait_dv(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step();
            if (data_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_dv_timeout: data_valid=0 after 400 cycles, required 1", tag);
        end
    endtask

    task automatic wait_rv(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            if (result_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_rv_timeout: result_valid=0 after 50 cycles, required 1", tag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; result_ready = 1'b0; set_res(4'b0000); fifo_empty = 1'b1;
        repeat (3) step();
        checks++;
        if ({data_valid, result_valid, busy, fifo_rd_en} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got dv/rv/busy/rd=%b required 0000", {data_valid, result_valid, busy, fifo_rd_en});
        end
        checks++;
        if (data_out !== '0 || result_bits !== 4'h0 || vec_count !== 4'h0) begin
            failures++;
            $display("FAIL reset_data: got slot0=%h bits=%h cnt=%0d required 0", data_out[1727:1664], result_bits, vec_count);
        end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got busy=%b rd=%b required 0 0", busy, fifo_rd_en);
        end
    endtask

    task automatic test_basic();
        int p0, n;
        bit stable;
        logic [1727:0] cap;
        set_res(4'b0101); result_ready = 1'b1; p0 = pops;
        push_vec(64'h1);
        wait_dv("basic");
        cap = data_out;
        checks++;
        if (data_out[1727:1664] !== 64'h1 || data_out[63:0] !== 64'h1B) begin
            failures++;
            $display("FAIL basic_ends: got slot0=%h slot26=%h required 1 1b", data_out[1727:1664], data_out[63:0]);
        end
        checks++;
        if (data_out !== mkvec(64'h1)) begin
            failures++;
            $display("FAIL basic_vec: got slot13=%h required %h", data_out[831:768], 64'hE);
        end
        n = 0; stable = 1'b1;
        while (!result_valid && n < 20) begin
            step(); n++;
            if (data_out !== cap) stable = 1'b0;
        end
        checks++;
        if (n !== 6) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles required 6", n);
        end
        checks++;
        if (result_bits !== 4'b0101) begin
            failures++;
            $display("FAIL basic_bits: got %b required 0101", result_bits);
        end
        step();
        checks++;
        if (result_valid !== 1'b0 || vec_count !== 4'd1) begin
            failures++;
            $display("FAIL basic_accept: got rv=%b cnt=%0d required 0 1", result_valid, vec_count);
        end
        checks++;
        if (pops - p0 !== 27 || !stable) begin
            failures++;
            $display("FAIL basic_pops: got pops=%0d stable=%b required 27 1", pops - p0, stable);
        end
    endtask

    task automatic test_gaps();
        int p0;
        gap_mode = 1'b1; set_res(4'b0011); result_ready = 1'b1; p0 = pops;
        push_vec(64'hA5A5_0000_0000_0100);
        wait_dv("gaps");
        checks++;
        if (data_out !== mkvec(64'hA5A5_0000_0000_0100)) begin
            failures++;
            $display("FAIL gaps_vec: got slot0=%h slot26=%h required a5a5000000000100 a5a500000000011a",
                     data_out[1727:1664], data_out[63:0]);
        end
        checks++;
        if (pops - p0 !== 27) begin
            failures++;
            $display("FAIL gaps_pops: got %0d required 27", pops - p0);
        end
        wait_rv("gaps");
        step();
        gap_mode = 1'b0;
        checks++;
        if (vec_count !== 4'd2 || result_bits !== 4'b0011) begin
            failures++;
            $display("FAIL gaps_result: got cnt=%0d bits=%b required 2 0011", vec_count, result_bits);
        end
    endtask

    task automatic test_backpressure();
        int p0;
        bit early, rv6, bad_v, bad_b, bad_rd, bad_d;
        logic [1727:0] cap;
        result_ready = 1'b0; set_res(4'b0011); p0 = pops;
        push_vec(64'h1111_0000_0000_0000);
        push_vec(64'h2222_0000_0000_0000);
        wait_dv("bp1");
        cap = data_out;
        checks++;
        if (data_out !== mkvec(64'h1111_0000_0000_0000)) begin
            failures++;
            $display("FAIL bp_vec1: got slot0=%h required 1111000000000000", data_out[1727:1664]);
        end
        early = 1'b0; rv6 = 1'b0;
        // Only the value driven in the fifth cycle after the strobe may be captured.
        for (int n = 1; n <= 6; n++) begin
            step();
            if (n < 6 && result_valid) early = 1'b1;
            if (n == 6) rv6 = result_valid;
            set_res(n == 5 ? 4'b1010 : (n < 5 ? 4'b0011 : 4'b0110));
        end
        checks++;
        if (early || !rv6) begin
            failures++;
            $display("FAIL bp_rv_timing: got early=%b rv_at6=%b required 0 1", early, rv6);
        end
        checks++;
        if (result_bits !== 4'b1010) begin
            failures++;
            $display("FAIL bp_sample: got %b required 1010", result_bits);
        end
        bad_v = 0; bad_b = 0; bad_rd = 0; bad_d = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (result_valid !== 1'b1) bad_v = 1;
            if (result_bits !== 4'b1010) bad_b = 1;
            if (fifo_rd_en !== 1'b0) bad_rd = 1;
            if (data_out !== cap) bad_d = 1;
            set_res(4'(i));
        end
        checks++;
        if (bad_v || bad_b) begin
            failures++;
            $display("FAIL bp_hold: got rv_drop=%b bits_change=%b required 0 0", bad_v, bad_b);
        end
        checks++;
        if (bad_rd || bad_d || pops - p0 !== 27) begin
            failures++;
            $display("FAIL bp_noprefetch: got rd=%b dchg=%b pops=%0d required 0 0 27", bad_rd, bad_d, pops - p0);
        end
        result_ready = 1'b1;
        set_res(4'b1100);
        step();
        checks++;
        if (result_valid !== 1'b0 || vec_count !== 4'd3) begin
            failures++;
            $display("FAIL bp_accept: got rv=%b cnt=%0d required 0 3", result_valid, vec_count);
        end
        wait_dv("bp2");
        checks++;
        if (data_out !== mkvec(64'h2222_0000_0000_0000)) begin
            failures++;
            $display("FAIL bp_vec2: got slot0=%h required 2222000000000000", data_out[1727:1664]);
        end
        wait_rv("bp2");
        checks++;
        if (result_bits !== 4'b1100) begin
            failures++;
            $display("FAIL bp_bits2: got %b required 1100", result_bits);
        end
        step();
        checks++;
        if (vec_count !== 4'd4 || pops - p0 !== 54) begin
            failures++;
            $display("FAIL bp_done: got cnt=%0d pops=%0d required 4 54", vec_count, pops - p0);
        end
    endtask

    task automatic test_reset_mid();
        int p0, i;
        result_ready = 1'b1; set_res(4'b1001); p0 = pops;
        for (int k = 0; k < 13; k++) q.push_back(64'hDEAD_0000_0000_0000 + 64'(k));
        set_empty();
        i = 0;
        while (pops - p0 < 13 && i < 50) begin step(); i++; end
        step();
        checks++;
        if (busy !== 1'b1 || pops - p0 !== 13) begin
            failures++;
            $display("FAIL mid_busy: got busy=%b pops=%0d required 1 13", busy, pops - p0);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (data_out !== '0 || vec_count !== 4'd0 || {busy, fifo_rd_en, result_valid, data_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_async: got slot26=%h cnt=%0d flags=%b required 0 0 0000",
                     data_out[63:0], vec_count, {busy, fifo_rd_en, result_valid, data_valid});
        end
        step();
        rst = 1'b0;
        push_vec(64'h7777_0000_0000_0000);
        wait_dv("mid");
        checks++;
        if (data_out !== mkvec(64'h7777_0000_0000_0000)) begin
            failures++;
            $display("FAIL mid_vec: got slot0=%h slot26=%h required 7777000000000000 777700000000001a",
                     data_out[1727:1664], data_out[63:0]);
        end
        wait_rv("mid");
        step();
        checks++;
        if (vec_count !== 4'd1 || result_bits !== 4'b1001) begin
            failures++;
            $display("FAIL mid_result: got cnt=%0d bits=%b required 1 1001", vec_count, result_bits);
        end
    endtask

    task automatic test_wrap();
        result_ready = 1'b1; set_res(4'b1111);
        for (int v = 0; v < 14; v++) begin
            push_vec(64'(v) << 32);
            wait_dv("wrap");
            wait_rv("wrap");
            step();
        end
        checks++;
        if (vec_count !== 4'd15) begin
            failures++;
            $display("FAIL wrap_15: got %0d required 15", vec_count);
        end
        push_vec(64'h5555_0000_0000_0000);
        wait_dv("wrap_last");
        checks++;
        if (data_out[1727:1664] !== 64'h5555_0000_0000_0000 || data_out[63:0] !== 64'h5555_0000_0000_001A) begin
            failures++;
            $display("FAIL wrap_vec: got slot0=%h slot26=%h required 5555000000000000 555500000000001a",
                     data_out[1727:1664], data_out[63:0]);
        end
        wait_rv("wrap_last");
        step();
        checks++;
        if (vec_count !== 4'd0) begin
            failures++;
            $display("FAIL wrap_0: got %0d required 0", vec_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clsf_feature_packer.md
Name: clsf_feature_packer

Overview:
Feeder and collector for the classifier tree. Pops narrow words from the RX FIFO and packs NUM_WORDS of them MSB-first into one 1728-bit feature vector. Presents the vector to the tree with a one-cycle data_valid strobe, waits the tree's fixed latency, then captures the four tree result bits. Returns them upstream on a valid/ready handshake.

Parameters:
WORD_W, 64, RX FIFO read-data width
NUM_WORDS, 27, words per feature vector (WORD_W*NUM_WORDS must equal VEC_W)
VEC_W, 1728, feature vector width driven to the tree
RESULT_LAT, 5, cycles from the data_valid strobe to tree results valid (minimum 1)
CNT_W, 16, width of the processed-vector counter

Ports:
rx_fifo_clock  in  1  sole clock, rising edge
rx_fifo_reset  in  1  asynchronous, active-high reset
fifo_empty  in  1  RX FIFO empty flag
fifo_rd_en  out  1  RX FIFO pop; read data returns one cycle later
fifo_dout  in  WORD_W  RX FIFO read data
data_out  out  VEC_W  feature vector to the tree
data_valid  out  1  one-cycle strobe qualifying data_out
clsf_result0  in  1  tree result bit 0
clsf_result1  in  1  tree result bit 1
clsf_result2  in  1  tree result bit 2
clsf_result_mul  in  1  tree combined result bit
result_valid  out  1  result_bits valid
result_ready  in  1  upstream accepts result
result_bits  out  4  {mul, r2, r1, r0}
vec_count  out  CNT_W  count of results accepted upstream
busy  out  1  high in any state other than FILL with zero words received

Behaviour:
- Reset (async assert, sync release) sets:
  - state FILL
  - fifo_rd_en, data_valid, result_valid, busy = 0
  - data_out, result_bits, vec_count, all internal counters = 0
- FSM states: FILL, ISSUE, WAIT, REPORT.
- FILL:
  - fifo_rd_en = !fifo_empty && (req_cnt < NUM_WORDS). It is combinational from the registered req_cnt.
  - Each pop increments req_cnt.
  - The cycle after a pop, fifo_dout is written into the pack register at word slot rcv_cnt. Slot 0 is bits [VEC_W-1 : VEC_W-WORD_W]; slot k is WORD_W*k bits below slot 0. rcv_cnt then increments.
  - The pack register is separate from data_out.
  - Never pop more than NUM_WORDS per vector. An empty FIFO stalls with no loss and no duplication.
  - When rcv_cnt reaches NUM_WORDS → ISSUE.
- ISSUE (1 cycle):
  - data_out is loaded from the pack register.
  - data_valid = 1 for exactly this cycle.
  - req_cnt and rcv_cnt are cleared.
  - Load a latency counter with RESULT_LAT-1, then → WAIT.
- data_out holds its value until the next ISSUE. The tree input stays stable while results propagate.
- WAIT:
  - The counter decrements each cycle. When it is 0, sample the four result inputs into result_bits, set result_valid = 1, and → REPORT.
  - With the default RESULT_LAT = 5, result_bits are sampled exactly RESULT_LAT cycles after the data_valid cycle and result_valid rises the following cycle.
- REPORT:
  - result_valid and result_bits are held stable until result_ready is high on a rising edge.
  - On acceptance: result_valid = 0, vec_count increments and wraps to 0 at all-ones, → FILL.
  - If result_ready is already high on the first REPORT cycle, the transfer completes in that single cycle.
- fifo_rd_en is 0 in every state except FILL. The next vector is not prefetched until the result is accepted, so only one vector is in flight.
- result_ready asserted outside REPORT is ignored.
- A mid-operation reset discards the partial vector and any pending result. Words already popped are lost; this is accepted behaviour.
- busy = (state != FILL) || (rcv_cnt != 0) || (req_cnt != 0).

Test Plan:
- 27 words 0x01..0x1B pushed back-to-back, result inputs tied to 4'b0101, result_ready = 1 → one data_valid pulse. data_out[1727:1664] = 0x01 and data_out[63:0] = 0x1B. result_bits = 4'b0101 with result_valid rising 6 cycles after data_valid. vec_count = 1.
- fifo_empty toggled randomly during fill → exactly 27 pops per vector, data_out identical to the gap-free case, no extra fifo_rd_en while req_cnt = 27.
- result_ready held low 10 cycles in REPORT with 28+ words queued → result_valid and result_bits stable, no fifo_rd_en until acceptance, then fill resumes and the second vector completes.
- Result inputs change after the sample cycle → result_bits retain the value sampled at latency RESULT_LAT. data_out stays constant through WAIT and REPORT.
- rx_fifo_reset asserted after 13 words → all outputs 0 immediately (asynchronous). The next 27 words form a clean vector with slot 0 = the first post-reset word.
- vec_count preset by running 2^CNT_W vectors (CNT_W = 4 override) → wraps 15→0 on the 16th acceptance.
